// File: rtl/chan_mux_pkg.sv
// Shared constants and helpers for the chan_mux_pipe slice.
// Round-robin arbitration is enabled by defining CHAN_MUX_RR_EN.
package chan_mux_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A select port needs at least one bit even for degenerate channel counts.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    localparam int DEF_N     = 4;
    localparam int DEF_SEL_W = sel_width(DEF_N);

    typedef logic [DEF_SEL_W-1:0] chan_idx_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker built as a double-width masked priority encoder.
// Only compiled when CHAN_MUX_RR_EN is defined.
`ifdef CHAN_MUX_RR_EN
module rr_pick
    import chan_mux_pkg::*;
#(
    parameter int N = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_grant,
    output logic             o_grant_valid
);

    localparam int IW = SEL_W + 1;

    logic [2*N-1:0] w_dbl;
    logic [IW-1:0]  w_idx;
    logic           w_found;

    assign w_dbl = {i_req, i_req};

    // Scanning downward lets the lowest set bit at or above the pointer win.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (w_dbl[i] && (i >= int'(i_ptr))) begin
                w_found = 1'b1;
                w_idx   = i[IW-1:0];
            end
        end
    end

    always_comb begin
        o_grant_valid = w_found;
        if (w_idx >= IW'(N)) begin
            o_grant = SEL_W'(w_idx - IW'(N));
        end else begin
            o_grant = SEL_W'(w_idx);
        end
    end

endmodule
`endif

// File: rtl/chan_mux_pipe.sv
// N-to-1 channel mux with a registered valid/ready output stage and transfer counter.
// Define CHAN_MUX_RR_EN for round-robin arbitration instead of the sel port.
module chan_mux_pipe
    import chan_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int CNT_W = 16,
    localparam int SEL_W = sel_width(N)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [SEL_W-1:0]   i_sel,
    input  logic [N-1:0]       i_in_valid,
    input  logic [N*W-1:0]     i_in_data,
    output logic [N-1:0]       o_in_ready,
    output logic               o_out_valid,
    output logic [W-1:0]       o_out_data,
    output logic [SEL_W-1:0]   o_out_chan,
    input  logic               i_out_ready,
    output logic [CNT_W-1:0]   o_xfer_cnt
);

    logic [SEL_W-1:0] w_grant;
    logic             w_grant_valid;
    logic             w_accept;
    logic             w_xfer;
    logic [W-1:0]     w_data;

    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic [CNT_W-1:0] r_xfer_cnt;

`ifdef CHAN_MUX_RR_EN
    logic [SEL_W-1:0] r_rr_ptr;
    logic [SEL_W-1:0] w_next_ptr;

    rr_pick #(.N(N)) u_rr_pick (
        .i_req         (i_in_valid),
        .i_ptr         (r_rr_ptr),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    assign w_next_ptr = (w_grant == SEL_W'(N - 1)) ? '0 : (w_grant + SEL_W'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= w_next_ptr;
        end
    end
`else
    // Select values past the last channel match nothing, so they never grant.
    always_comb begin
        w_grant       = i_sel;
        w_grant_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_sel == SEL_W'(i)) begin
                w_grant_valid = i_in_valid[i];
            end
        end
    end
`endif

    assign w_accept = !r_out_valid || i_out_ready;
    assign w_xfer   = w_accept && w_grant_valid && !i_rst;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_data = i_in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        o_in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (w_xfer && (w_grant == SEL_W'(i))) begin
                o_in_ready[i] = 1'b1;
            end
        end
    end

    // A load takes priority over a drain so a same-edge drain and fill keeps valid high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_xfer_cnt  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_chan  <= w_grant;
            r_xfer_cnt  <= r_xfer_cnt + CNT_W'(1);
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_chan  = r_out_chan;
    assign o_xfer_cnt  = r_xfer_cnt;

endmodule
